counter_timer_ctrl: RTL and testbench
=====================================

Name: counter_timer_ctrl

Overview:
Programmable interval-timer controller that sequences a free-running up-counter into one-shot or periodic timing runs.
- Holds a shadow configuration: period, prescale and mode.
- Gates counter increments through a prescaler.
- Detects terminal count and raises an expiry pulse plus a sticky interrupt.
- Sits between a simple register/strobe interface and the 32-bit counter datapath, replacing the bare sync-reset counter wherever timed events are needed.

Parameters:
WIDTH, 32, counter and period width in bits
PRESCALE_W, 8, prescale divider width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  write strobe for cfg_period/cfg_prescale/cfg_periodic
cfg_period  input  WIDTH  ticks per run; 0 is illegal
cfg_prescale  input  PRESCALE_W  clocks per tick minus 1
cfg_periodic  input  1  1=periodic reload, 0=one-shot
start  input  1  start/restart strobe
stop  input  1  abort strobe
irq_ack  input  1  clears irq
count  output  WIDTH  current counter value
busy  output  1  1 while in RUN
done  output  1  1 while in DONE
expire  output  1  one-cycle pulse at terminal count
irq  output  1  sticky interrupt

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, immediate, including mid-run): state=IDLE, count=0, prescale_cnt=0, busy=0, done=0, expire=0, irq=0, shadow period/prescale/periodic=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1.
- cfg_we:
  - Accepted in IDLE or DONE; ignored in RUN.
  - If cfg_we and start are high in the same cycle, the start uses the newly written values.
- start:
  - In IDLE, DONE or RUN with effective period!=0 and stop=0: next edge count=0, prescale_cnt=0, state=RUN, expire=0.
  - start in RUN is a restart and produces no expire.
  - Effective period==0: start ignored; state unchanged.
- RUN prescaling:
  - prescale_cnt increments each clock.
  - tick = (prescale_cnt==shadow prescale); on tick prescale_cnt←0.
  - Prescale 0 gives a tick every clock.
- RUN counting on tick:
  - If count!=period-1: count←count+1.
  - Terminal (count==period-1):
    - periodic: count←0, stay RUN.
    - one-shot: count←period, state←DONE, count frozen.
    - Either mode: expire=1 for exactly that cycle, registered and coincident with the new count value; irq←1.
- Latency: start sampled at edge N gives first increment at edge N+(prescale+1). Expiry interval is period*(prescale+1) clocks.
- Full range: period=2^WIDTH-1 is legal. Arithmetic is unsigned modulo 2^WIDTH; count never exceeds period.
- stop in RUN: state←IDLE, count and prescale_cnt hold, no expire.
- Collisions:
  - stop on the terminal tick: stop wins, no expire, irq unchanged.
  - start together with stop: stop wins.
- irq: cleared by irq_ack. A set and an ack in the same cycle: set wins.
- DONE/IDLE: count holds until the next start.

Decomposition:
- Shared package counter_timer_pkg holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2, 2'd3 illegal→IDLE.
  - default WIDTH/PRESCALE_W constants.
- Sub-module count_core(WIDTH): clk, rst (async high), clr, inc, count out.
  - clr has priority over inc.
- Controller holds the FSM, prescaler, shadow registers and irq, and drives clr/inc.

Test Plan:
- Reset mid-run: assert rst while count=7 → within the same cycle count=0, busy=0, irq=0, state IDLE.
- One-shot, period=4, prescale=0, start at edge N:
  - count 1,2,3 at N+1..N+3.
  - At N+4: count=4, expire=1 for one cycle, done=1, busy=0.
  - count stays 4 for 20 more cycles.
- Periodic, period=3, prescale=2: expire every 9 clocks for 4 periods; count sequence 0,1,2,0; irq stays 1 until irq_ack, then 0.
- Boundary collisions:
  - stop on the terminal tick → no expire, state IDLE, count=period-1.
  - irq_ack on an expire cycle → irq=1.
  - start+stop together in IDLE → no run.
- Config rules:
  - cfg_we in RUN (period 5→10) → run still expires at 5.
  - cfg_we+start with period=10 → expiry after 10 ticks.
  - start with period=0 → stays IDLE, busy=0.
- Restart: start at count=2 of a period-4 run → count=0 next edge, no expire; expiry 4 ticks later.

Source files
------------

// File: rtl/counter_timer_pkg.sv
// Shared encodings and default sizes for the interval-timer controller.
package counter_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_PRESCALE_W = 8;

endpackage : counter_timer_pkg

// File: rtl/counter_timer_ctrl_count_core.sv
// Bare up-counter datapath: clear has priority over increment.
module count_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : count_core

// File: rtl/counter_timer_ctrl.sv
// Interval-timer controller: shadow config, prescaler, one-shot/periodic FSM,
// expiry pulse and sticky interrupt around a plain up-counter.
module counter_timer_ctrl
   import counter_timer_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [WIDTH-1:0]      cfg_period,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   input  logic                  cfg_periodic,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  irq_ack,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  done,
   output logic                  expire,
   output logic                  irq
);

   state_e                state_d,    state_q;
   logic [PRESCALE_W-1:0] psc_d,      psc_q;
   logic [WIDTH-1:0]      period_d,   period_q;
   logic [PRESCALE_W-1:0] prescale_d, prescale_q;
   logic                  periodic_d, periodic_q;
   logic                  expire_d,   expire_q;
   logic                  irq_d,      irq_q;

   logic             clr;
   logic             inc;
   logic [WIDTH-1:0] eff_period;
   logic             start_ok;
   logic             tick;
   logic             terminal;

   count_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc),
      .count (count)
   );

   // A write landing with start must be seen by that start, so look through the shadow.
   assign eff_period = (cfg_we && (state_q != ST_RUN)) ? cfg_period : period_q;
   assign start_ok   = start && !stop && (eff_period != '0);
   assign tick       = (psc_q == prescale_q);
   assign terminal   = tick && (count == period_q - WIDTH'(1));

   always_comb begin
      state_d    = state_q;
      psc_d      = psc_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      periodic_d = periodic_q;
      expire_d   = 1'b0;
      irq_d      = irq_q && !irq_ack;
      clr        = 1'b0;
      inc        = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (cfg_we) begin
               period_d   = cfg_period;
               prescale_d = cfg_prescale;
               periodic_d = cfg_periodic;
            end
            if (start_ok) begin
               state_d = ST_RUN;
               psc_d   = '0;
               clr     = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start_ok) begin
               psc_d = '0;
               clr   = 1'b1;
            end else if (tick) begin
               psc_d = '0;
               if (terminal) begin
                  expire_d = 1'b1;
                  irq_d    = 1'b1;
                  if (periodic_q) begin
                     clr = 1'b1;
                  end else begin
                     // One-shot parks at count==period.
                     inc     = 1'b1;
                     state_d = ST_DONE;
                  end
               end else begin
                  inc = 1'b1;
               end
            end else begin
               psc_d = psc_q + PRESCALE_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         psc_q      <= '0;
         period_q   <= '0;
         prescale_q <= '0;
         periodic_q <= 1'b0;
         expire_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         psc_q      <= psc_d;
         period_q   <= period_d;
         prescale_q <= prescale_d;
         periodic_q <= periodic_d;
         expire_q   <= expire_d;
         irq_q      <= irq_d;
      end
   end

   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);
   assign expire = expire_q;
   assign irq    = irq_q;

endmodule : counter_timer_ctrl

// File: tb/tb_counter_timer_ctrl.sv
// Directed self-checking bench for counter_timer_ctrl.
module tb_counter_timer_ctrl;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [31:0] cfg_period;
   logic [7:0]  cfg_prescale;
   logic        cfg_periodic;
   logic        start;
   logic        stop;
   logic        irq_ack;
   logic [31:0] count;
   logic        busy;
   logic        done;
   logic        expire;
   logic        irq;

   int pass_cnt  = 0;
   int total_cnt = 0;

   counter_timer_ctrl #(.WIDTH(32), .PRESCALE_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_period   (cfg_period),
      .cfg_prescale (cfg_prescale),
      .cfg_periodic (cfg_periodic),
      .start        (start),
      .stop         (stop),
      .irq_ack      (irq_ack),
      .count        (count),
      .busy         (busy),
      .done         (done),
      .expire       (expire),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; outputs are then sampled 1ns after the edge.
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg(input logic [31:0] p, input logic [7:0] ps, input logic per);
      cfg_period   = p;
      cfg_prescale = ps;
      cfg_periodic = per;
      cfg_we       = 1'b1;
      cyc();
      cfg_we       = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc(2);
      total_cnt++; if (count !== 32'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (expire !== 1'b0) $display("FAIL reset_expire: got %b want 0", expire); else pass_cnt++;
      total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_oneshot;
      cfg(32'd4, 8'd0, 1'b0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      total_cnt++; if (count !== 32'd0) $display("FAIL os_start_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL os_start_busy: got %b want 1", busy); else pass_cnt++;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         total_cnt++; if (count !== 32'(i)) $display("FAIL os_count: got %0d want %0d", count, i); else pass_cnt++;
         total_cnt++; if (expire !== 1'b0) $display("FAIL os_early_expire: got %b want 0 at step %0d", expire, i); else pass_cnt++;
      end
      cyc();
      total_cnt++; if (count !== 32'd4) $display("FAIL os_term_count: got %0d want 4", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b1) $display("FAIL os_term_expire: got %b want 1", expire); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL os_term_done: got %b want 1", done); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL os_term_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (irq !== 1'b1) $display("FAIL os_term_irq: got %b want 1", irq); else pass_cnt++;
      cyc();
      total_cnt++; if (expire !== 1'b0) $display("FAIL os_expire_width: got %b want 0", expire); else pass_cnt++;
      for (int i = 0; i < 20; i++) begin
         cyc();
         total_cnt++; if (count !== 32'd4) $display("FAIL os_frozen: got %0d want 4 at hold %0d", count, i); else pass_cnt++;
      end
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      total_cnt++; if (irq !== 1'b0) $display("FAIL os_irq_ack: got %b want 0", irq); else pass_cnt++;
   endtask

   task automatic test_periodic;
      logic [31:0] exp_c;
      logic        exp_e;
      logic        exp_i;
      cfg_period   = 32'd3;
      cfg_prescale = 8'd2;
      cfg_periodic = 1'b1;
      cfg_we       = 1'b1;
      start        = 1'b1;
      cyc();
      cfg_we = 1'b0;
      start  = 1'b0;
      total_cnt++; if (count !== 32'd0) $display("FAIL per_start_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL per_start_busy: got %b want 1", busy); else pass_cnt++;
      for (int k = 1; k <= 36; k++) begin
         irq_ack = (k == 12) || (k == 18);
         cyc();
         irq_ack = 1'b0;
         exp_c = 32'((k / 3) % 3);
         exp_e = (k % 9 == 0);
         exp_i = (k >= 9 && k < 12) || (k >= 18);
         total_cnt++; if (count !== exp_c) $display("FAIL per_count: got %0d want %0d at clk %0d", count, exp_c, k); else pass_cnt++;
         total_cnt++; if (expire !== exp_e) $display("FAIL per_expire: got %b want %b at clk %0d", expire, exp_e, k); else pass_cnt++;
         total_cnt++; if (irq !== exp_i) $display("FAIL per_irq: got %b want %b at clk %0d", irq, exp_i, k); else pass_cnt++;
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL per_stop_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL per_stop_done: got %b want 0", done); else pass_cnt++;
      cyc(5);
      total_cnt++; if (count !== 32'd0) $display("FAIL per_stop_hold: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (irq !== 1'b1) $display("FAIL per_irq_sticky: got %b want 1", irq); else pass_cnt++;
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      total_cnt++; if (irq !== 1'b0) $display("FAIL per_irq_ack: got %b want 0", irq); else pass_cnt++;
   endtask

   task automatic test_stop_terminal;
      cfg(32'd4, 8'd0, 1'b0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(3);
      total_cnt++; if (count !== 32'd3) $display("FAIL st_pre_count: got %0d want 3", count); else pass_cnt++;
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      total_cnt++; if (expire !== 1'b0) $display("FAIL st_expire: got %b want 0", expire); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL st_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL st_done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (count !== 32'd3) $display("FAIL st_count: got %0d want 3", count); else pass_cnt++;
      total_cnt++; if (irq !== 1'b0) $display("FAIL st_irq: got %b want 0", irq); else pass_cnt++;
      cyc();
      total_cnt++; if (expire !== 1'b0) $display("FAIL st_late_expire: got %b want 0", expire); else pass_cnt++;
   endtask

   task automatic test_start_stop;
      start = 1'b1;
      stop  = 1'b1;
      cyc();
      start = 1'b0;
      stop  = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL ss_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (count !== 32'd3) $display("FAIL ss_count: got %0d want 3", count); else pass_cnt++;
      cyc(3);
      total_cnt++; if (count !== 32'd3) $display("FAIL ss_hold: got %0d want 3", count); else pass_cnt++;
   endtask

   task automatic test_cfg_in_run;
      cfg(32'd5, 8'd0, 1'b0);
      start = 1'b1;
      cyc();
      start      = 1'b0;
      cfg_period = 32'd10;
      cfg_we     = 1'b1;
      cyc();
      cfg_we = 1'b0;
      cyc(3);
      total_cnt++; if (count !== 32'd4) $display("FAIL cr_count4: got %0d want 4", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b0) $display("FAIL cr_early: got %b want 0", expire); else pass_cnt++;
      cyc();
      total_cnt++; if (count !== 32'd5) $display("FAIL cr_term_count: got %0d want 5", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b1) $display("FAIL cr_expire: got %b want 1", expire); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL cr_done: got %b want 1", done); else pass_cnt++;
   endtask

   task automatic test_cfg_start;
      cfg_period   = 32'd10;
      cfg_prescale = 8'd0;
      cfg_periodic = 1'b0;
      cfg_we       = 1'b1;
      start        = 1'b1;
      cyc();
      cfg_we = 1'b0;
      start  = 1'b0;
      cyc(5);
      total_cnt++; if (count !== 32'd5) $display("FAIL cs_count5: got %0d want 5", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b0) $display("FAIL cs_old_period: got %b want 0", expire); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL cs_busy: got %b want 1", busy); else pass_cnt++;
      cyc(4);
      total_cnt++; if (count !== 32'd9) $display("FAIL cs_count9: got %0d want 9", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b0) $display("FAIL cs_early: got %b want 0", expire); else pass_cnt++;
      cyc();
      total_cnt++; if (count !== 32'd10) $display("FAIL cs_term_count: got %0d want 10", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b1) $display("FAIL cs_expire: got %b want 1", expire); else pass_cnt++;
   endtask

   task automatic test_period_zero;
      cfg(32'd4, 8'd0, 1'b0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(2);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      total_cnt++; if (count !== 32'd2) $display("FAIL pz_setup: got %0d want 2", count); else pass_cnt++;
      cfg(32'd0, 8'd0, 1'b0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL pz_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL pz_done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (count !== 32'd2) $display("FAIL pz_count: got %0d want 2", count); else pass_cnt++;
   endtask

   task automatic test_restart;
      cfg(32'd4, 8'd0, 1'b0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(2);
      total_cnt++; if (count !== 32'd2) $display("FAIL rs_pre: got %0d want 2", count); else pass_cnt++;
      start = 1'b1;
      cyc();
      start = 1'b0;
      total_cnt++; if (count !== 32'd0) $display("FAIL rs_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b0) $display("FAIL rs_expire: got %b want 0", expire); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL rs_busy: got %b want 1", busy); else pass_cnt++;
      cyc(3);
      total_cnt++; if (count !== 32'd3) $display("FAIL rs_count3: got %0d want 3", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b0) $display("FAIL rs_early: got %b want 0", expire); else pass_cnt++;
      cyc();
      total_cnt++; if (count !== 32'd4) $display("FAIL rs_term_count: got %0d want 4", count); else pass_cnt++;
      total_cnt++; if (expire !== 1'b1) $display("FAIL rs_term_expire: got %b want 1", expire); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL rs_term_done: got %b want 1", done); else pass_cnt++;
   endtask

   task automatic test_reset_mid_run;
      cfg(32'd20, 8'd0, 1'b0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(7);
      total_cnt++; if (count !== 32'd7) $display("FAIL rm_pre: got %0d want 7", count); else pass_cnt++;
      rst = 1'b1;
      #1;
      total_cnt++; if (count !== 32'd0) $display("FAIL rm_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (irq !== 1'b0) $display("FAIL rm_irq: got %b want 0", irq); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL rm_done: got %b want 0", done); else pass_cnt++;
      cyc();
      rst = 1'b0;
      cyc(3);
      total_cnt++; if (busy !== 1'b0) $display("FAIL rm_idle_after: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (count !== 32'd0) $display("FAIL rm_count_after: got %0d want 0", count); else pass_cnt++;
   endtask

   initial begin
      rst          = 1'b1;
      cfg_we       = 1'b0;
      cfg_period   = '0;
      cfg_prescale = '0;
      cfg_periodic = 1'b0;
      start        = 1'b0;
      stop         = 1'b0;
      irq_ack      = 1'b0;

      test_reset();
      test_oneshot();
      test_periodic();
      test_stop_terminal();
      test_start_stop();
      test_cfg_in_run();
      test_cfg_start();
      test_period_zero();
      test_restart();
      test_reset_mid_run();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_counter_timer_ctrl
